// File: rtl/micro_sequencer.sv
// Microcode sequencer: steps micro-addresses, alternates fetch and execute microprograms, dispatches interrupts.
// Optional single-step support is enabled with `define MICRO_SEQUENCER_SINGLE_STEP_EN.
module micro_sequencer #(
  parameter int OPCODE_W = 6,
  parameter int UADDR_W  = 6,
  parameter int HALT_CH  = 6,
  parameter int FETCH_OP = 0,
  parameter int IRQ_OP   = 63
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] instr_opcode,
  input  logic                ucode_end,
  input  logic [HALT_CH-1:0]  halt_req,
  input  logic [HALT_CH-1:0]  halt_busy,
  input  logic                irq,
  input  logic                irq_en,
`ifdef MICRO_SEQUENCER_SINGLE_STEP_EN
  input  logic                step_mode,
  input  logic                step_pulse,
`endif
  output logic [OPCODE_W-1:0] cur_op,
  output logic [UADDR_W-1:0]  uaddr,
  output logic                halted,
  output logic [HALT_CH-1:0]  halt_cause,
  output logic                irq_taken,
  output logic                fault
);

  localparam logic [OPCODE_W-1:0] FETCH     = OPCODE_W'(FETCH_OP);
  localparam logic [OPCODE_W-1:0] IRQ_ENTRY = OPCODE_W'(IRQ_OP);
  localparam logic [UADDR_W-1:0]  UADDR_MAX = '1;

  logic irq_q;
  logic irq_pend;
  logic irq_rise;
  logic step_hold;
  logic fetch_end;
  logic irq_dispatch;

  assign halt_cause = halt_req & halt_busy;
  assign halted     = |halt_cause;
  assign irq_rise   = irq & ~irq_q;
  assign fetch_end  = ucode_end && (cur_op == FETCH);

`ifdef MICRO_SEQUENCER_SINGLE_STEP_EN
  // In step mode the fetch end waits for a step pulse; this is a hold, not a halt.
  assign step_hold = step_mode & ~step_pulse;
`else
  assign step_hold = 1'b0;
`endif

  assign irq_dispatch = ~halted & fetch_end & ~step_hold & irq_pend & irq_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_op    <= FETCH;
      uaddr     <= '0;
      irq_q     <= 1'b0;
      irq_pend  <= 1'b0;
      irq_taken <= 1'b0;
      fault     <= 1'b0;
    end else begin
      irq_q     <= irq;
      irq_taken <= irq_dispatch;
      // A new edge wins over a same-cycle dispatch clear.
      if (irq_rise)
        irq_pend <= 1'b1;
      else if (irq_dispatch)
        irq_pend <= 1'b0;

      if (!halted) begin
        if (ucode_end) begin
          if (cur_op != FETCH) begin
            cur_op <= FETCH;
            uaddr  <= '0;
          end else if (!step_hold) begin
            cur_op <= (irq_pend && irq_en) ? IRQ_ENTRY : instr_opcode;
            uaddr  <= '0;
          end
        end else if (uaddr == UADDR_MAX) begin
          // Runaway microprogram: abort to fetch and flag it permanently.
          cur_op <= FETCH;
          uaddr  <= '0;
          fault  <= 1'b1;
        end else begin
          uaddr <= uaddr + UADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter OPCODE_W, default 6, opcode width.
REQ-002 Parameter UADDR_W, default 6, micro-step counter width.
REQ-003 Parameter HALT_CH, default 6, number of halt channels.
REQ-004 Parameter FETCH_OP, default 0, opcode of the instruction-fetch microprogram.
REQ-005 Parameter IRQ_OP, default 63, opcode of the interrupt-entry microprogram.
REQ-006 Port: clk  in  1  system clock; all state changes on its rising edge.
REQ-007 Port: reset  in  1  asynchronous, active-high reset.
REQ-008 Port: instr_opcode  in  OPCODE_W  opcode from the instruction register.
REQ-009 Port: ucode_end  in  1  current micro-word is the end marker.
REQ-010 Port: halt_req  in  HALT_CH  per-channel halt enable from the micro-word.
REQ-011 Port: halt_busy  in  HALT_CH  per-channel busy status; tie high for an unconditional halt.
REQ-012 Port: irq  in  1  interrupt request, level.
REQ-013 Port: irq_en  in  1  interrupt enable.
REQ-014 Port: cur_op  out  OPCODE_W  opcode currently sequencing.
REQ-015 Port: uaddr  out  UADDR_W  current micro-step.
REQ-016 Port: halted  out  1  sequencer stalled this cycle (combinational).
REQ-017 Port: halt_cause  out  HALT_CH  halt_req & halt_busy (combinational).
REQ-018 Port: irq_taken  out  1  one-cycle pulse on interrupt dispatch.
REQ-019 Port: fault  out  1  sticky micro-step overflow flag.

Function
REQ-020 halted SHALL equal |(halt_req & halt_busy); when halted is high, cur_op, uaddr and fault SHALL hold, and no dispatch SHALL occur.
REQ-021 When not halted and ucode_end=0, uaddr SHALL increment by 1 per clock.
REQ-022 When not halted, ucode_end=1 and cur_op!=FETCH_OP, the next clock SHALL set uaddr=0 and cur_op=FETCH_OP.
REQ-023 When not halted, ucode_end=1 and cur_op==FETCH_OP, the next clock SHALL set uaddr=0 and cur_op=IRQ_OP if irq_pend&irq_en, else instr_opcode.
REQ-024 irq_pend SHALL be set on a rising edge of irq (registered previous value), and SHALL be cleared on the clock that dispatches IRQ_OP; a set and a clear in the same cycle SHALL leave it set.
REQ-025 irq_taken SHALL be high for exactly the one cycle after an IRQ_OP dispatch.
REQ-026 An irq edge arriving while irq_en=0 SHALL remain pending until irq_en=1 at a fetch end.
REQ-027 Overflow: when not halted, uaddr is all-ones and ucode_end=0, the next clock SHALL set uaddr=0, cur_op=FETCH_OP and fault=1.
REQ-028 fault SHALL be cleared only by reset.
REQ-029 When halted and ucode_end are both high, halt SHALL win; the end is honoured on the first un-halted cycle.
REQ-030 uaddr SHALL never wrap silently; REQ-027 is the only wrap path.

Reset
REQ-031 While reset is high: cur_op=FETCH_OP, uaddr=0, irq_pend=0, irq_taken=0, fault=0, registered irq=0.
REQ-032 Reset asserted mid-microprogram SHALL abandon it; the first post-reset clock SHALL begin the fetch microprogram at uaddr 0.

Configuration
REQ-033 Macro MICRO_SEQUENCER_SINGLE_STEP_EN SHALL select single-step support.
REQ-034 With the macro defined, the block SHALL add ports step_mode (in, 1) and step_pulse (in, 1).
REQ-035 With the macro defined and step_mode=1, the FETCH_OP end SHALL dispatch only on a cycle where step_pulse=1; otherwise it holds at that end, and halted SHALL stay low.
REQ-036 With the macro undefined, those ports SHALL be absent and behaviour SHALL follow REQ-020..030 exactly.

Verification
REQ-037 Reset, instr_opcode=5, fetch ends at uaddr=2 -> cur_op=5 and uaddr=0 on the next clock; exec ends at uaddr=3 -> cur_op=0.
REQ-038 halt_req=6'b000100, halt_busy=6'b000100 for 4 cycles mid-exec at uaddr=1 -> halted=1 and halt_cause=4; uaddr stays 1 for 4 cycles, then increments to 2.
REQ-039 irq rising edge during exec with irq_en=1 -> at the next fetch end cur_op=63, irq_taken high for 1 cycle, irq_pend cleared; a second edge with irq_en=0 -> instr_opcode dispatched and pending retained.
REQ-040 ucode_end held 0 from uaddr=0 -> after 64 clocks uaddr=0, cur_op=0, fault=1; fault stays 1 until reset.
REQ-041 reset pulsed at uaddr=3 of opcode 9 -> cur_op=0, uaddr=0, fault=0 immediately (asynchronous).
REQ-042 With MICRO_SEQUENCER_SINGLE_STEP_EN, step_mode=1 and no step_pulse for 10 cycles at fetch end -> cur_op=0 held; one step_pulse -> instr_opcode dispatched.
